// File: rtl/csa_iter_mul.sv
// -----------------------------------------------------------------------------
// csa_iter_mul -- iterative RV32M multiplier built around a carry-save
// accumulator.
//
// Operand magnitudes are latched on acceptance. Each CALC cycle consumes
// BITS_PER_CYCLE multiplier bits: one partial product per bit is folded into
// the sum/carry accumulators through a chain of 3:2 compressors. A single
// ADD cycle then resolves sum+carry, applies the sign, and selects the
// requested half of the 2*XLEN product.
//
// Optional feature (macro MUL_ZERO_BYPASS_EN): when either effective operand
// is zero at acceptance, the FSM skips CALC/ADD and presents a zero result
// one edge after the accept edge.
//
// Parameters:
//   XLEN            operand width
//   BITS_PER_CYCLE  multiplier bits retired per CALC cycle (1, 2, 4 or 8)
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   request valid                 o_ready   unit can accept
//   i_op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_a       rs1 (multiplicand)            i_b       rs2 (multiplier)
//   i_flush   synchronous kill of any in-flight operation
//   o_valid   result valid                  i_ready   consumer accepts
//   o_result  selected half of the product
// -----------------------------------------------------------------------------
module csa_iter_mul #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * XLEN;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    generate
        if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
              (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8)) ||
            ((XLEN % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
            $error("csa_iter_mul: BITS_PER_CYCLE must be 1, 2, 4 or 8 and divide XLEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   a_shift_reg;   // multiplicand, pre-shifted to current bit position
    logic [XLEN-1:0] b_shift_reg;   // multiplier, consumed from the LSB end
    logic [PW-1:0]   sum_reg;
    logic [PW-1:0]   carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic            neg_reg;
    logic [1:0]      op_reg;
    logic [XLEN-1:0] result_reg;

    // ------------------------------------------------------------------
    // Operand decode: magnitudes are XLEN-bit unsigned, so -2^31 maps to
    // 0x80000000 without needing an extra bit.
    // ------------------------------------------------------------------
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            neg_in;

    always_comb begin
        a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
        b_signed = (i_op == OP_MULH);
        a_neg    = a_signed & i_a[XLEN-1];
        b_neg    = b_signed & i_b[XLEN-1];
        a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
        b_mag    = b_neg ? (~i_b + 1'b1) : i_b;
        neg_in   = a_neg ^ b_neg;
    end

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_in;
    assign zero_in = (a_mag == '0) || (b_mag == '0);
`endif

    // ------------------------------------------------------------------
    // Carry-save chain: level 0 is the accumulator pair, each further
    // level absorbs one partial product. Carries are kept pre-shifted so
    // sum+carry always equals the accumulated value (mod 2^PW).
    // ------------------------------------------------------------------
    logic [PW-1:0] pp    [BITS_PER_CYCLE];
    logic [PW-1:0] lvl_s [BITS_PER_CYCLE+1];
    logic [PW-1:0] lvl_c [BITS_PER_CYCLE+1];

    assign lvl_s[0] = sum_reg;
    assign lvl_c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_csa
            assign pp[gi]      = b_shift_reg[gi] ? (a_shift_reg << gi) : '0;
            assign lvl_s[gi+1] = lvl_s[gi] ^ lvl_c[gi] ^ pp[gi];
            assign lvl_c[gi+1] = ((lvl_s[gi] & lvl_c[gi]) |
                                  (lvl_s[gi] & pp[gi])    |
                                  (lvl_c[gi] & pp[gi])) << 1;
        end
    endgenerate

    // Final carry-propagate add and sign fix-up.
    logic [PW-1:0] p_raw, p_fin;
    always_comb begin
        p_raw = sum_reg + carry_reg;
        p_fin = neg_reg ? (~p_raw + 1'b1) : p_raw;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (i_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
`ifdef MUL_ZERO_BYPASS_EN
                        state_next = zero_in ? OUT : CALC;
`else
                        state_next = CALC;
`endif
                    end
                end
                CALC:    if (cnt_reg == '0) state_next = ADD;
                ADD:     state_next = OUT;
                OUT:     if (i_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and state registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            a_shift_reg <= '0;
            b_shift_reg <= '0;
            sum_reg     <= '0;
            carry_reg   <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            op_reg      <= 2'b00;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (i_flush) begin
                result_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (i_valid) begin
                            a_shift_reg <= {{XLEN{1'b0}}, a_mag};
                            b_shift_reg <= b_mag;
                            sum_reg     <= '0;
                            carry_reg   <= '0;
                            cnt_reg     <= CW'(STEPS - 1);
                            neg_reg     <= neg_in;
                            op_reg      <= i_op;
`ifdef MUL_ZERO_BYPASS_EN
                            if (zero_in) result_reg <= '0;
`endif
                        end
                    end
                    CALC: begin
                        sum_reg     <= lvl_s[BITS_PER_CYCLE];
                        carry_reg   <= lvl_c[BITS_PER_CYCLE];
                        a_shift_reg <= a_shift_reg << BITS_PER_CYCLE;
                        b_shift_reg <= b_shift_reg >> BITS_PER_CYCLE;
                        cnt_reg     <= cnt_reg - 1'b1;
                    end
                    ADD: begin
                        result_reg <= (op_reg == OP_MUL) ? p_fin[XLEN-1:0]
                                                         : p_fin[PW-1:XLEN];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ready  = (state_reg == IDLE);
    assign o_valid  = (state_reg == OUT);
    assign o_result = result_reg;

endmodule
